mac_array_seq: RTL and testbench

Parametrised, sequenced matrix-vector MAC engine: computes C[r] = sum over k of A[r][k]*B[k] for ROWS parallel lanes, streaming one A column and one B element per accepted beat. Successor to the fixed-DEPTH vectored MAC array. Adds:
- a start/len command with a control FSM
- valid/ready handshakes on input and output
- a selectable signed mode
- per-lane sticky overflow flags

Sits between the operand FIFOs (upstream) and the result consumer (downstream).

---
 rtl/mac_array_seq.sv | 121 ++++++++++++
 tb/tb_mac_array_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_seq.sv
// mac_array_seq: sequenced ROWS-lane matrix-vector multiply-accumulate engine.
// One A column and one B element per accepted beat; result held until accepted.
module mac_array_seq #(
    parameter int ROWS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic                     signed_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   a_in,
    input  logic [DATA_W-1:0]        b_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROWS*ACC_W-1:0]    c_out,
    output logic [ROWS-1:0]          ovf,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]    count;
    logic [LEN_W-1:0]    len_q;
    logic                sgn;
    logic                load;
    logic                beat;
    logic                last;
    logic [ACC_W-1:0]    acc [ROWS];
    logic [ACC_W-1:0]    sum_w [ROWS];
    logic [ROWS-1:0]     ovf_beat;
    logic [2*DATA_W-1:0] b_ext;

    assign load  = (state == IDLE) && start;
    assign beat  = in_valid && in_ready;
    assign last  = (count == len_q - LEN_W'(1));
    assign b_ext = sgn ? {{DATA_W{b_in[DATA_W-1]}}, b_in}
                       : {{DATA_W{1'b0}}, b_in};

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_W-1:0]   a;
        logic [2*DATA_W-1:0] a_ext;
        logic [2*DATA_W-1:0] prod;
        logic [ACC_W-1:0]    p_s;
        logic [ACC_W-1:0]    p_u;
        logic [ACC_W-1:0]    pext;
        logic [ACC_W:0]      sum;

        assign a     = a_in[r*DATA_W +: DATA_W];
        assign a_ext = sgn ? {{DATA_W{a[DATA_W-1]}}, a}
                           : {{DATA_W{1'b0}}, a};
        // Low 2*DATA_W bits of the extended product are exact in both modes
        assign prod  = a_ext * b_ext;
        assign p_s   = ACC_W'($signed(prod));
        assign p_u   = ACC_W'(prod);
        assign pext  = sgn ? p_s : p_u;
        assign sum   = {1'b0, acc[r]} + {1'b0, pext};
        assign sum_w[r] = sum[ACC_W-1:0];
        assign ovf_beat[r] = sgn
            ? ((acc[r][ACC_W-1] == pext[ACC_W-1]) &&
               (sum[ACC_W-1] != acc[r][ACC_W-1]))
            : sum[ACC_W];
        assign c_out[r*ACC_W +: ACC_W] = acc[r];
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulators, sticky overflow, beat counter and latched command
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) acc[r] <= '0;
            ovf   <= '0;
            count <= '0;
            len_q <= '0;
            sgn   <= 1'b0;
        end else if (load) begin
            for (int r = 0; r < ROWS; r++) acc[r] <= '0;
            ovf   <= '0;
            count <= '0;
            len_q <= len;
            sgn   <= signed_en;
        end else if (beat) begin
            for (int r = 0; r < ROWS; r++) acc[r] <= sum_w[r];
            ovf   <= ovf | ovf_beat;
            count <= count + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_mac_array_seq.sv
// tb_mac_array_seq: two instances (24-bit and 16-bit accumulators) on shared
// stimulus, compared every cycle against an integer-arithmetic model.
module tb_mac_array_seq;

    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int LW   = 8;
    localparam int WA   = 24;
    localparam int WB   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [LW-1:0]     len = '0;
    logic              signed_en = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [ROWS*DW-1:0] a_in = '0;
    logic [DW-1:0]     b_in = '0;

    logic              ir_a, ov_a, busy_a;
    logic              ir_b, ov_b, busy_b;
    logic [ROWS*WA-1:0] c_a;
    logic [ROWS*WB-1:0] c_b;
    logic [ROWS-1:0]   ovf_a, ovf_b;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    int              phase = 0;
    int              left = 0;
    bit              msgn = 0;
    longint          acc_a [ROWS];
    longint          acc_b [ROWS];
    logic [ROWS-1:0] movf_a = '0;
    logic [ROWS-1:0] movf_b = '0;

    mac_array_seq #(.ROWS(ROWS), .DATA_W(DW), .ACC_W(WA), .LEN_W(LW)) u_a (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .signed_en(signed_en), .in_valid(in_valid), .in_ready(ir_a),
        .a_in(a_in), .b_in(b_in), .out_valid(ov_a), .out_ready(out_ready),
        .c_out(c_a), .ovf(ovf_a), .busy(busy_a)
    );

    mac_array_seq #(.ROWS(ROWS), .DATA_W(DW), .ACC_W(WB), .LEN_W(LW)) u_b (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .signed_en(signed_en), .in_valid(in_valid), .in_ready(ir_b),
        .a_in(a_in), .b_in(b_in), .out_valid(ov_b), .out_ready(out_ready),
        .c_out(c_b), .ovf(ovf_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint lane_prod(input int r, input bit sgn);
        logic [DW-1:0] a;
        a = a_in[r*DW +: DW];
        if (sgn) return longint'($signed(a)) * longint'($signed(b_in));
        return longint'(a) * longint'(b_in);
    endfunction

    // Exact sum, range check for overflow, then wrap to w bits
    function automatic void accum(input longint acc_in, input longint p,
                                  input int w, input bit sgn,
                                  output longint acc_out, output bit ov);
        longint m, s, lo, hi;
        m = longint'(1) << w;
        s = acc_in;
        if (sgn && s >= m / 2) s = s - m;
        s = s + p;
        lo = sgn ? -(m / 2) : 0;
        hi = sgn ? (m / 2 - 1) : (m - 1);
        ov = (s < lo) || (s > hi);
        acc_out = s & (m - 1);
    endfunction

    function automatic void clear_model();
        for (int r = 0; r < ROWS; r++) begin
            acc_a[r] = 0;
            acc_b[r] = 0;
        end
        movf_a = '0;
        movf_b = '0;
    endfunction

    // Reference model: advances on each rising edge from the sampled inputs
    initial begin
        clear_model();
        forever begin
            @(posedge clk);
            if (rst) begin
                phase = 0;
                left = 0;
                msgn = 0;
                clear_model();
            end else if (phase == 0) begin
                if (start) begin
                    clear_model();
                    msgn = signed_en;
                    if (len == 0) phase = 2;
                    else begin
                        phase = 1;
                        left = int'(len);
                    end
                end
            end else if (phase == 1) begin
                if (in_valid) begin
                    for (int r = 0; r < ROWS; r++) begin
                        longint p, na;
                        bit o;
                        p = lane_prod(r, msgn);
                        accum(acc_a[r], p, WA, msgn, na, o);
                        acc_a[r] = na;
                        if (o) movf_a[r] = 1'b1;
                        accum(acc_b[r], p, WB, msgn, na, o);
                        acc_b[r] = na;
                        if (o) movf_b[r] = 1'b1;
                    end
                    left--;
                    if (left == 0) phase = 2;
                end
            end else begin
                if (out_ready) phase = 0;
            end
        end
    end

    // Compare process: every cycle, on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("in_ready_a", ir_a, phase == 1);
                chk("out_valid_a", ov_a, phase == 2);
                chk("busy_a", busy_a, phase != 0);
                chk("in_ready_b", ir_b, phase == 1);
                chk("out_valid_b", ov_b, phase == 2);
                chk("busy_b", busy_b, phase != 0);
                chk("ovf_a", ovf_a, movf_a);
                chk("ovf_b", ovf_b, movf_b);
                for (int r = 0; r < ROWS; r++) begin
                    chk($sformatf("c_a[%0d]", r), c_a[r*WA +: WA], acc_a[r]);
                    chk($sformatf("c_b[%0d]", r), c_b[r*WB +: WB], acc_b[r]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int n, input bit sg);
        start = 1'b1;
        len = LW'(n);
        signed_en = sg;
        tick();
        start = 1'b0;
    endtask

    task automatic accept();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [6:0] pat;

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk_on = 1;
        chk("rst_busy", busy_a, 0);
        chk("rst_out_valid", ov_a, 0);
        rst = 1'b0;

        // Unsigned len=3, back-to-back beats
        cmd(3, 0);
        chk("t1_in_ready", ir_a, 1);
        a_in = {8'd4, 8'd3, 8'd2, 8'd1};
        in_valid = 1'b1;
        b_in = 8'd2;
        tick();
        b_in = 8'd3;
        tick();
        chk("t1_early_valid", ov_a, 0);
        b_in = 8'd4;
        tick();
        chk("t1_out_valid", ov_a, 1);
        for (int r = 0; r < ROWS; r++)
            chk($sformatf("t1_c[%0d]", r), c_a[r*WA +: WA], 9 * (r + 1));
        chk("t1_model_c0", acc_a[0], 9);
        chk("t1_ovf", ovf_a, 0);
        accept();
        chk("t1_idle", busy_a, 0);

        // Signed and unsigned with a = 0xFD, b = 5
        cmd(2, 1);
        a_in = {4{8'hFD}};
        b_in = 8'd5;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t2s_valid", ov_a, 1);
        chk("t2s_c_a", c_a[WA-1:0], 24'hFFFFE2);
        chk("t2s_c_b", c_b[WB-1:0], 16'hFFE2);
        chk("t2s_model", acc_a[3], 24'hFFFFE2);
        chk("t2s_ovf", ovf_a | ovf_b, 0);
        accept();
        cmd(2, 0);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t2u_c_a", c_a[2*WA +: WA], 2530);
        chk("t2u_c_b", c_b[2*WB +: WB], 2530);
        chk("t2u_ovf", ovf_a | ovf_b, 0);
        accept();

        // Input gaps and output backpressure
        cmd(4, 0);
        a_in = {8'd4, 8'd3, 8'd2, 8'd1};
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            b_in = pat[i] ? 8'd1 : 8'd9;
            tick();
            if (i == 5) chk("t3_early_valid", ov_a, 0);
        end
        in_valid = 1'b0;
        chk("t3_valid", ov_a, 1);
        for (int j = 0; j < 5; j++) begin
            start = (j == 2);
            len = 8'd5;
            tick();
            chk("t3_hold_valid", ov_a, 1);
            chk("t3_hold_c0", c_a[WA-1:0], 4);
            chk("t3_hold_c3", c_a[3*WA +: WA], 16);
        end
        start = 1'b0;
        accept();
        chk("t3_idle", busy_a, 0);
        chk("t3_keep_c1", c_a[WA +: WA], 8);

        // Overflow on the 16-bit instance
        cmd(2, 0);
        a_in = {4{8'hFF}};
        b_in = 8'hFF;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t4_c_b", c_b[WB-1:0], 16'hFC02);
        chk("t4_ovf_b", ovf_b, 4'hF);
        chk("t4_model_ovf", movf_b, 4'hF);
        chk("t4_c_a", c_a[WA-1:0], 130050);
        chk("t4_ovf_a", ovf_a, 0);
        accept();
        chk("t4_ovf_kept", ovf_b, 4'hF);
        cmd(1, 0);
        chk("t4_ovf_clr", ovf_b, 0);
        a_in = {4{8'd1}};
        b_in = 8'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t4_c_next", c_b[WB-1:0], 1);
        accept();

        // Zero-length command
        cmd(0, 0);
        chk("t5_valid", ov_a, 1);
        chk("t5_in_ready", ir_a, 0);
        chk("t5_c", c_a[WA-1:0], 0);
        chk("t5_ovf", ovf_a, 0);
        accept();
        chk("t5_idle", busy_a, 0);

        // Reset mid-command, then a fresh command
        cmd(5, 0);
        a_in = {8'd9, 8'd8, 8'd7, 8'd6};
        b_in = 8'd3;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy_a, 0);
        chk("t6_in_ready", ir_a, 0);
        chk("t6_out_valid", ov_a, 0);
        chk("t6_c", c_a[WA-1:0], 0);
        chk("t6_ovf", ovf_a, 0);
        cmd(1, 0);
        a_in = {8'd4, 8'd3, 8'd2, 8'd1};
        b_in = 8'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t6_valid", ov_a, 1);
        chk("t6_c1", c_a[WA +: WA], 6);
        accept();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 3) == 0);
            len = LW'($urandom_range(0, 6));
            signed_en = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 2) != 0);
            a_in = $urandom;
            b_in = DW'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
